// File: rtl/gray_display_ctrl.sv
// Gray-code monitor with a 4-digit multiplexed seven-segment display.
// Decodes gray_in to binary, counts input changes, flags illegal steps.
//
// Ports:
//   clk       system clock, all state on posedge
//   rst       asynchronous active-high reset
//   gray_in   4-bit Gray code from upstream counter
//   err_clr   level-sensitive clear of step_err
//   bin_out   registered binary of the sampled Gray code
//   step_err  sticky illegal-transition flag
//   step_cnt  8-bit wrapping count of input changes
//   an        active-low one-hot digit enable
//   seg       active-low segments {g,f,e,d,c,b,a}
module gray_display_ctrl #(
  parameter int unsigned REFRESH_DIV = 100_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] gray_in,
  input  logic       err_clr,
  output logic [3:0] bin_out,
  output logic       step_err,
  output logic [7:0] step_cnt,
  output logic [3:0] an,
  output logic [6:0] seg
);

  localparam int unsigned CW =
    (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(REFRESH_DIV - 1);
  localparam logic [6:0] BLANK = 7'b1111111;

  logic [3:0]    g_q;
  logic [3:0]    g_prev;
  logic [3:0]    bin_c;
  logic [3:0]    diff;
  logic          change;
  logic          legal;
  logic          bad_step;
  logic [CW-1:0] ref_cnt;
  logic [1:0]    idx;
  logic [3:0]    ones;
  logic          tens;
  logic [6:0]    seg_c;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  always_comb begin
    bin_c[3] = g_q[3];
    bin_c[2] = bin_c[3] ^ g_q[2];
    bin_c[1] = bin_c[2] ^ g_q[1];
    bin_c[0] = bin_c[1] ^ g_q[0];
  end

  // One-bit difference is legal; a drop to zero is the
  // upstream counter restarting and is also accepted.
  assign diff     = g_q ^ g_prev;
  assign change   = (diff != 4'd0);
  assign legal    = ((diff & (diff - 4'd1)) == 4'd0)
                    || (g_q == 4'd0);
  assign bad_step = change && !legal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g_q      <= '0;
      g_prev   <= '0;
      bin_out  <= '0;
      step_cnt <= '0;
      step_err <= 1'b0;
    end else begin
      g_q     <= gray_in;
      g_prev  <= g_q;
      bin_out <= bin_c;
      if (change)
        step_cnt <= step_cnt + 8'd1;
      // Set has priority over a coincident clear.
      if (bad_step)
        step_err <= 1'b1;
      else if (err_clr)
        step_err <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_cnt <= '0;
      idx     <= 2'd0;
    end else if (ref_cnt == TERM) begin
      ref_cnt <= '0;
      idx     <= idx + 2'd1;
    end else begin
      ref_cnt <= ref_cnt + 1'b1;
    end
  end

  assign tens = (bin_out >= 4'd10);
  assign ones = tens ? (bin_out - 4'd10) : bin_out;

  always_comb begin
    seg_c = BLANK;
    case (idx)
      2'd0: seg_c = hex7(ones);
      2'd1: seg_c = tens ? hex7(4'h1) : BLANK;
      2'd2: seg_c = hex7(g_q);
      default: seg_c = step_err ? hex7(4'hE) : BLANK;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= 4'b1110;
      seg <= BLANK;
    end else begin
      an  <= ~(4'b0001 << idx);
      seg <= seg_c;
    end
  end

endmodule

// File: tb/tb_gray_display_ctrl.sv
// Scoreboard bench for gray_display_ctrl.
// Stimulus queues expectations tagged by cycle; a monitor compares.
module tb_gray_display_ctrl;

  localparam int DIV = 4;
  localparam int K_BIN = 0;
  localparam int K_CNT = 1;
  localparam int K_ERR = 2;
  localparam int K_AN  = 3;
  localparam int K_SEG = 4;

  localparam logic [6:0] S_BL = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] gray_in;
  logic       err_clr;
  logic [3:0] bin_out;
  logic       step_err;
  logic [7:0] step_cnt;
  logic [3:0] an;
  logic [6:0] seg;

  gray_display_ctrl #(.REFRESH_DIV(DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .gray_in  (gray_in),
    .err_clr  (err_clr),
    .bin_out  (bin_out),
    .step_err (step_err),
    .step_cnt (step_cnt),
    .an       (an),
    .seg      (seg)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         c;
    int         k;
    logic [7:0] v;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   rel = 0;

  function automatic logic [7:0] dut_val(input int k);
    logic [7:0] r;
    case (k)
      K_BIN:   r = {4'h0, bin_out};
      K_CNT:   r = step_cnt;
      K_ERR:   r = {7'h0, step_err};
      K_AN:    r = {4'h0, an};
      default: r = {1'b0, seg};
    endcase
    return r;
  endfunction

  function automatic string kname(input int k);
    string s;
    case (k)
      K_BIN:   s = "bin_out";
      K_CNT:   s = "step_cnt";
      K_ERR:   s = "step_err";
      K_AN:    s = "an";
      default: s = "seg";
    endcase
    return s;
  endfunction

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].c <= cyc) begin
        checks++;
        if (sb[i].c < cyc) begin
          errors++;
          $display("FAIL %s stale entry cyc %0d now %0d",
                   kname(sb[i].k), sb[i].c, cyc);
        end else if (dut_val(sb[i].k) !== sb[i].v) begin
          errors++;
          $display("FAIL %s cyc %0d got %0h expected %0h",
                   kname(sb[i].k), cyc, dut_val(sb[i].k),
                   sb[i].v);
        end
        sb.delete(i);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int c, input int k,
                      input logic [7:0] v);
    exp_t e;
    e.c = c;
    e.k = k;
    e.v = v;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [3:0] g,
                       input logic [3:0] b);
    gray_in = g;
    push(cyc + 2, K_BIN, {4'h0, b});
    tick();
  endtask

  task automatic settle();
    repeat (3) tick();
  endtask

  task automatic check_display(input logic [6:0] s0,
                               input logic [6:0] s1,
                               input logic [6:0] s2,
                               input logic [6:0] s3);
    logic [6:0] tbl [4];
    int d;
    tbl[0] = s0;
    tbl[1] = s1;
    tbl[2] = s2;
    tbl[3] = s3;
    settle();
    for (int i = 0; i < 16; i++) begin
      d = ((cyc - 1 - rel) / DIV) % 4;
      push(cyc, K_AN, {4'h0, ~(4'b0001 << d)});
      push(cyc, K_SEG, {1'b0, tbl[d]});
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cyc %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    int n;
    logic [3:0] g;
    rst = 1'b1;
    gray_in = 4'h0;
    err_clr = 1'b0;
    tick();
    push(cyc + 1, K_BIN, 8'h00);
    push(cyc + 1, K_CNT, 8'h00);
    push(cyc + 1, K_ERR, 8'h00);
    push(cyc + 1, K_AN,  8'h0E);
    push(cyc + 1, K_SEG, 8'h7F);
    tick();
    tick();
    rst = 1'b0;
    rel = cyc;

    // Legal walk 0,1,3,2, each held two cycles
    drive(4'b0000, 4'd0); drive(4'b0000, 4'd0);
    drive(4'b0001, 4'd1); drive(4'b0001, 4'd1);
    drive(4'b0011, 4'd2); drive(4'b0011, 4'd2);
    drive(4'b0010, 4'd3); drive(4'b0010, 4'd3);
    settle();
    push(cyc, K_CNT, 8'd3);
    push(cyc, K_ERR, 8'd0);

    drive(4'b0011, 4'd2); drive(4'b0011, 4'd2);
    drive(4'b0001, 4'd1); drive(4'b0001, 4'd1);

    // Illegal step 0001 -> 0111, exact timing
    c = cyc;
    push(c + 1, K_ERR, 8'd0);
    push(c + 1, K_CNT, 8'd5);
    push(c + 2, K_ERR, 8'd1);
    push(c + 2, K_CNT, 8'd6);
    drive(4'b0111, 4'd5);
    drive(4'b0111, 4'd5);
    check_display(7'b0010010, S_BL, 7'b1111000, 7'b0000110);

    // Clear with no change
    c = cyc;
    err_clr = 1'b1;
    push(c + 1, K_ERR, 8'd0);
    push(c + 2, K_ERR, 8'd0);
    tick();
    err_clr = 1'b0;
    tick();

    // Clear coincident with illegal 0111 -> 0100
    drive(4'b0100, 4'd7);
    err_clr = 1'b1;
    push(cyc + 1, K_ERR, 8'd1);
    tick();
    err_clr = 1'b0;
    push(cyc + 1, K_ERR, 8'd1);
    tick();
    settle();
    push(cyc, K_CNT, 8'd7);

    err_clr = 1'b1;
    push(cyc + 1, K_ERR, 8'd0);
    tick();
    err_clr = 1'b0;

    // Legal walk to 1011, then exempt drop to 0000
    drive(4'b1100, 4'd8);  drive(4'b1100, 4'd8);
    drive(4'b1110, 4'd11); drive(4'b1110, 4'd11);
    drive(4'b1010, 4'd12); drive(4'b1010, 4'd12);
    drive(4'b1011, 4'd13); drive(4'b1011, 4'd13);
    drive(4'b0000, 4'd0);  drive(4'b0000, 4'd0);
    settle();
    push(cyc, K_CNT, 8'd12);
    push(cyc, K_ERR, 8'd0);
    drive(4'b1000, 4'd15); drive(4'b1000, 4'd15);
    settle();
    push(cyc, K_CNT, 8'd13);
    push(cyc, K_ERR, 8'd0);
    check_display(7'b0010010, 7'b1111001, 7'b0000000, S_BL);

    // Asynchronous reset while digit 2 is lit
    settle();
    n = 0;
    while (!((((cyc - rel) / DIV) % 4 == 2) &&
             (((cyc - 1 - rel) / DIV) % 4 == 2)) && n < 64) begin
      tick();
      n++;
    end
    #2;
    rst = 1'b1;
    gray_in = 4'h0;
    push(cyc, K_AN,  8'h0E);
    push(cyc, K_SEG, 8'h7F);
    push(cyc, K_BIN, 8'h00);
    push(cyc, K_CNT, 8'h00);
    push(cyc, K_ERR, 8'h00);
    tick();
    rst = 1'b0;
    rel = cyc;
    for (int i = 1; i <= 16; i++) begin
      n = ((cyc - rel) / DIV) % 4;
      push(cyc + 1, K_AN, {4'h0, ~(4'b0001 << n)});
      push(cyc + 1, K_SEG,
           {1'b0, (n == 0 || n == 2) ? 7'b1000000 : S_BL});
      tick();
    end

    // 255 legal changes, then one more to wrap
    for (int i = 0; i < 255; i++) begin
      g = (i % 2 == 0) ? 4'b0001 : 4'b0000;
      drive(g, g);
    end
    settle();
    push(cyc, K_CNT, 8'd255);
    push(cyc, K_ERR, 8'd0);
    drive(4'b0000, 4'd0);
    settle();
    push(cyc, K_CNT, 8'd0);
    push(cyc, K_ERR, 8'd0);

    n = 0;
    while (sb.size() > 0 && n < 10) begin
      tick();
      n++;
    end
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain %0d entries left, expected 0",
               sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
